// File: rtl/stream_pkg.sv
// Shared definitions for the credit-based stream link (transmitter and receiver ends).
// Both ends size their credit counters with credit_w so the counter widths always match.
package stream_pkg;

    function automatic int credit_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : stream_pkg

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with registered zero/full flags.
// It also produces a single-cycle overflow pulse when a credit arrives while full.
module credit_counter
    import stream_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = credit_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         full,
    output logic         overflow
);

    typedef logic [W-1:0] cnt_t;

    localparam cnt_t MAX_C = cnt_t'(MAX);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic zero_q;
    logic full_q;

    // A simultaneous inc and dec cancels out; decrementing at zero is ignored.
    always_comb begin
        cnt_d    = cnt_q;
        overflow = 1'b0;
        case ({dec, inc})
            2'b10: begin
                if (!zero_q) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            2'b01: begin
                if (full_q) begin
                    overflow = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Flags are registered from the next count so downstream users see pure flop outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= MAX_C;
            zero_q <= 1'b0;
            full_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
            full_q <= (cnt_d == MAX_C);
        end
    end

    assign count = cnt_q;
    assign zero  = zero_q;
    assign full  = full_q;

endmodule : credit_counter

// File: rtl/stream_credit_tx.sv
// Credit-based stream transmitter: forwards valid/ready beats to a receiver without backpressure,
// sending only while credits remain; the receiver returns one credit per drained entry.
module stream_credit_tx
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CREDITS    = 4,
    parameter bit REG_OUTPUT = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [DATA_WIDTH-1:0]          in_data_i,
    output logic                           out_valid_o,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    input  logic                           credit_i,
    output logic [credit_w(CREDITS)-1:0]   credits_o,
    output logic                           idle_o,
    output logic                           err_o
);

    localparam int CW = credit_w(CREDITS);

    typedef logic [DATA_WIDTH-1:0] payload_t;
    typedef logic [CW-1:0]         count_t;

    logic   acc;
    logic   cnt_zero;
    logic   cnt_full;
    logic   overflow;
    logic   err_q;
    logic   beat_pending;
    count_t cnt;

    // Ready comes straight from the registered zero flag, so it never depends on this cycle's inputs.
    assign in_ready_o = ~cnt_zero;
    assign acc        = in_valid_i & in_ready_o;

    credit_counter #(
        .MAX (CREDITS),
        .W   (CW)
    ) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .dec      (acc),
        .inc      (credit_i),
        .count    (cnt),
        .zero     (cnt_zero),
        .full     (cnt_full),
        .overflow (overflow)
    );

    // An excess credit means the receiver and transmitter disagree on occupancy; latch it until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (overflow) begin
            err_q <= 1'b1;
        end
    end

    generate
        if (REG_OUTPUT) begin : g_reg_out
            logic     out_valid_q;
            payload_t out_data_q;

            // The receiver cannot stall, so each beat lives in this register for exactly one cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else if (acc) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= in_data_i;
                end else begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end
            end

            assign out_valid_o  = out_valid_q;
            assign out_data_o   = out_data_q;
            assign beat_pending = out_valid_q;
        end else begin : g_comb_out
            assign out_valid_o  = acc;
            assign out_data_o   = acc ? in_data_i : payload_t'(0);
            assign beat_pending = 1'b0;
        end
    endgenerate

    assign credits_o = cnt;
    assign idle_o    = cnt_full & ~beat_pending;
    assign err_o     = err_q;

endmodule : stream_credit_tx

// File: tb/tb_stream_credit_tx.sv
// Scoreboard bench for stream_credit_tx: a registered-output instance carries the main traffic,
// a pass-through instance covers the zero-latency build.
module tb_stream_credit_tx;

    localparam int DW = 8;
    localparam int CR = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          credit_i;
    logic [CW-1:0] credits_o;
    logic          idle_o;
    logic          err_o;

    logic          v0;
    logic          ready0;
    logic [DW-1:0] d0;
    logic          out_valid0;
    logic [DW-1:0] out_data0;
    logic          c0;
    logic [CW-1:0] credits0;
    logic          idle0;
    logic          err0;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  expq[$];
    int          mcnt;
    bit          merr;

    stream_credit_tx #(.DATA_WIDTH(DW), .CREDITS(CR), .REG_OUTPUT(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .credit_i    (credit_i),
        .credits_o   (credits_o),
        .idle_o      (idle_o),
        .err_o       (err_o)
    );

    stream_credit_tx #(.DATA_WIDTH(DW), .CREDITS(CR), .REG_OUTPUT(1'b0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (v0),
        .in_ready_o  (ready0),
        .in_data_i   (d0),
        .out_valid_o (out_valid0),
        .out_data_o  (out_data0),
        .credit_i    (c0),
        .credits_o   (credits0),
        .idle_o      (idle0),
        .err_o       (err0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every beat the DUT presents must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_o) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(out_valid_o), 32'd0);
                end else begin
                    checkOutput("beat_data", 32'(out_data_o), 32'(expq.pop_front()));
                end
            end else begin
                checkOutput("idle_data_zero", 32'(out_data_o), 32'd0);
            end
        end
    end

    // Drive one cycle of inputs, advance the credit model, and check the flop-driven outputs.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit c, output bit acc);
        in_valid_i = v;
        in_data_i  = d;
        credit_i   = c;
        acc = v && (mcnt != 0);
        if (acc) expq.push_back(d);
        @(posedge clk);
        #1;
        if (acc && !c) begin
            mcnt--;
        end else if (!acc && c) begin
            if (mcnt == CR) merr = 1'b1;
            else mcnt++;
        end
        checkOutput("credits", 32'(credits_o), 32'(mcnt));
        checkOutput("ready", 32'(in_ready_o), 32'(mcnt != 0));
        checkOutput("err", 32'(err_o), 32'(merr));
        checkOutput("idle", 32'(idle_o), 32'((mcnt == CR) && !acc));
    endtask

    task automatic doReset();
        rst        = 1'b1;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        credit_i   = 1'b0;
        v0         = 1'b0;
        d0         = '0;
        c0         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        mcnt = CR;
        merr = 1'b0;
        expq.delete();
        checkOutput("rst_ready", 32'(in_ready_o), 32'd1);
        checkOutput("rst_credits", 32'(credits_o), 32'(CR));
        checkOutput("rst_idle", 32'(idle_o), 32'd1);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("rst_out_data", 32'(out_data_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         acc;
        logic [7:0] d;

        doReset();

        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0, acc);

        d = 8'h01;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, d, 1'b0, acc);
            if (acc) d = d + 8'h01;
        end
        checkOutput("held_data", 32'(d), 32'h05);

        applyStimulus(1'b1, d, 1'b1, acc);
        applyStimulus(1'b1, d, 1'b0, acc);
        checkOutput("credit_return_accept", 32'(acc), 32'd1);

        applyStimulus(1'b0, 8'h00, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 1'b1, acc);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b1, acc);

        applyStimulus(1'b0, 8'h00, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 1'b1, acc);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, acc);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 1'b0, acc);
        @(negedge clk);
        checkOutput("drained_before_reset", 32'(expq.size()), 32'd0);

        doReset();
        checkOutput("rst0_err", 32'(err0), 32'd0);
        checkOutput("rst0_idle", 32'(idle0), 32'd1);

        v0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d0 = 8'(8'h40 + i);
            applyStimulus(1'b0, 8'h00, 1'b0, acc);
        end
        d0 = 8'hA5;
        #1;
        checkOutput("pt_credits", 32'(credits0), 32'd1);
        checkOutput("pt_valid", 32'(out_valid0), 32'd1);
        checkOutput("pt_data", 32'(out_data0), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b0, acc);
        checkOutput("pt_ready_drop", 32'(ready0), 32'd0);
        checkOutput("pt_credits_zero", 32'(credits0), 32'd0);
        checkOutput("pt_valid_blocked", 32'(out_valid0), 32'd0);
        checkOutput("pt_data_zero", 32'(out_data0), 32'd0);
        v0 = 1'b0;

        @(negedge clk);
        checkOutput("drained_final", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stream_credit_tx

// File: doc/stream_credit_tx.md
# stream_credit_tx

Credit-based stream transmitter: accepts a valid/ready stream on its input and forwards each beat to a downstream receiver that has no ready signal, sending only while it holds credits. Downstream returns one credit per drained entry via a pulse. It is the sending end of the credit link whose receiving end is a buffer of `CREDITS` entries. `in_ready_o` is a pure flop output, so no combinational path crosses the link.

## Interface
- `DATA_WIDTH`, 8, payload width in bits
- `CREDITS`, 4, receiver buffer depth; initial and maximum credit count, must be ≥1
- `REG_OUTPUT`, 1, 1 = registered `out_valid_o`/`out_data_o`; 0 = combinational pass-through
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset; synchronous, active-high
- `in_valid_i`  in  1  upstream beat valid
- `in_ready_o`  out  1  upstream ready; equals (credit count != 0)
- `in_data_i`  in  DATA_WIDTH  upstream payload
- `out_valid_o`  out  1  beat sent to receiver this cycle; consumes one credit
- `out_data_o`  out  DATA_WIDTH  payload; zero when `out_valid_o`=0
- `credit_i`  in  1  one credit returned per cycle it is high
- `credits_o`  out  $clog2(CREDITS+1)  current credit count
- `idle_o`  out  1  credit count == CREDITS and no beat in the output register
- `err_o`  out  1  sticky; set on credit overflow, cleared only by `rst`

## Operation
- Counter `cnt` has width $clog2(CREDITS+1) and resets to CREDITS.
- Accept: `acc = in_valid_i & in_ready_o`, with `in_ready_o = (cnt != 0)` taken from the flop.
- Counter update: `cnt_next = cnt - acc + credit_i`.
  - Accept and credit in the same cycle: net change 0.
  - Accept at cnt==1 with no credit: cnt becomes 0 and `in_ready_o` drops the next cycle.
  - Credit at cnt==0: cnt becomes 1 and ready returns the next cycle.
- Overflow: `credit_i` while cnt==CREDITS and no accept in the same cycle.
  - cnt saturates at CREDITS.
  - `err_o` sets next cycle and stays set.
  - Data path is unaffected.
- Underflow cannot occur, because accepting requires cnt≠0.
- REG_OUTPUT=1:
  - On `acc`, `out_valid_o`<=1 and `out_data_o`<=`in_data_i`.
  - Otherwise `out_valid_o`<=0 and `out_data_o`<=0.
  - No stall is possible downstream, so the output register never holds a beat longer than one cycle.
- REG_OUTPUT=0: `out_valid_o = acc`; `out_data_o = acc ? in_data_i : 0`.
- No state machine; all state is `cnt`, `err`, and the optional output register.
- Reset mid-stream: cnt returns to CREDITS, the output beat is dropped, and `err_o` clears. The receiver must be reset in the same cycle.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `out_data_o`=0, `credits_o`=CREDITS, `idle_o`=1, `err_o`=0.
- Latency, `in` accept to `out_valid_o`: 1 cycle for REG_OUTPUT=1, 0 cycles for REG_OUTPUT=0.
- `credits_o` reflects the flop value; an accept or credit appears in it 1 cycle later.
- Credit-to-ready latency: 1 cycle.
- Sustained throughput is 1 beat/cycle when the credit round trip ≤ CREDITS cycles.
- `in_ready_o` does not depend on `credit_i` or `in_valid_i` in the same cycle.

## Structure
- Shared package `stream_pkg`:
  - Function `credit_w(n)` returning $clog2(n+1).
  - Reused by the matching receiver block.
- Payload typedef and counter typedef are local to the module, since they depend on parameters.
- One natural sub-module: `credit_counter`.
  - Saturating up/down counter with init value, `dec`/`inc` inputs, `zero`/`full` outputs and an overflow pulse.
  - The top level adds the accept logic, the output register and the sticky error.

## Test plan
- Reset, no traffic, CREDITS=4: all outputs hold their reset values for 10 cycles.
- Credit exhaustion: `in_valid_i`=1 with data 0x01..0x06 and no credits returned.
  - Exactly 0x01..0x04 appear on `out_data_o` on consecutive cycles, 1 cycle after each accept.
  - `in_ready_o`=0 from the cycle after the 4th accept; `credits_o`=0.
- Credit return:
  - From cnt=0, pulse `credit_i` once: `in_ready_o`=1 next cycle and 0x05 is sent.
  - Then `credits_o` returns to 0.
- Simultaneous accept and credit at cnt=2 for 8 cycles: `credits_o` stays at 2 and 8 beats pass in order.
- Overflow: `credit_i`=1 at cnt=4 with no valid.
  - `err_o`=1 next cycle; `credits_o` stays 4.
  - `err_o` stays set after traffic resumes and clears only on `rst`.
- REG_OUTPUT=0 build: `in_data_i`=0xA5 with valid at cnt=1 gives `out_valid_o`=1 and `out_data_o`=0xA5 in the same cycle, then `in_ready_o`=0.
